ram_port_arb: RTL and testbench

RAM_PORT_ARB -- requirements
Module: ram_port_arb

---
 rtl/ram_port_arb.sv | 215 +++++++++++++++++++++
 tb/tb_ram_port_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// ram_port_arb: two-requester write arbiter in front of a single BRAM port.
// Each requester streams pixels into its own address region.
// Grants alternate on ties and are capped at BURST_LEN beats.
// Each requester has its own wrapping address counter, rewound by done_i.
// Optional feature: define RAM_PORT_ARB_STATS_EN to add per-requester transfer counters.
module ram_port_arb #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned ADDR_STEP    = 4,
  parameter logic [31:0] BASE0        = 32'h0000_0000,
  parameter logic [31:0] BASE1        = 32'h0001_0000,
  parameter int unsigned REGION_WORDS = 16384,
  parameter int unsigned BURST_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m0_done_i,
  output logic                  m0_ready_o,
  input  logic                  m1_valid_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic                  m1_done_i,
  output logic                  m1_ready_o,
  output logic [31:0]           ram_addr_o,
  output logic [31:0]           ram_dout_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_wr_en_o,
  output logic [1:0]            grant_o
`ifdef RAM_PORT_ARB_STATS_EN
  ,
  output logic [31:0]           m0_words_o,
  output logic [31:0]           m1_words_o
`endif
);

  // Counter widths, kept at least one bit wide for degenerate parameter values.
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned IDX_W  = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REGION_WORDS - 1);
  localparam logic [31:0]       STEP      = 32'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [BEAT_W-1:0] beat_cnt;
  logic              burst_end;
  logic              xfer0;
  logic              xfer1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;

  // Handshake qualifiers: a word moves only while its requester holds the grant.
  always_comb begin
    xfer0     = (state == G0) && m0_valid_i;
    xfer1     = (state == G1) && m1_valid_i;
    burst_end = (beat_cnt == BEAT_LAST);
  end

  // Next-state logic: round-robin on ties, grant released on a gap or a full burst.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_valid_i && m1_valid_i) begin
          state_next = last_grant ? G0 : G1;
        end else if (m0_valid_i) begin
          state_next = G0;
        end else if (m1_valid_i) begin
          state_next = G1;
        end
      end
      G0: begin
        if (!m0_valid_i || burst_end) begin
          state_next = IDLE;
        end
      end
      G1: begin
        if (!m1_valid_i || burst_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant and ready decode straight from the state register.
  always_comb begin
    grant_o    = 2'b00;
    m0_ready_o = 1'b0;
    m1_ready_o = 1'b0;
    case (state)
      G0: begin
        grant_o    = 2'b01;
        m0_ready_o = 1'b1;
      end
      G1: begin
        grant_o    = 2'b10;
        m1_ready_o = 1'b1;
      end
      default: begin
        grant_o    = 2'b00;
        m0_ready_o = 1'b0;
        m1_ready_o = 1'b0;
      end
    endcase
  end

  // State register, tie-break memory and per-grant beat counter.
  // After reset requester 1 counts as last granted, so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == G0) begin
        last_grant <= 1'b0;
        beat_cnt   <= '0;
      end else if (state == IDLE && state_next == G1) begin
        last_grant <= 1'b1;
        beat_cnt   <= '0;
      end else if (xfer0 || xfer1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Requester-0 address counter: wraps inside its region, done rewinds it and wins over a transfer.
  always_ff @(posedge clk) begin
    if (rst || m0_done_i) begin
      addr0 <= BASE0;
      idx0  <= '0;
    end else if (xfer0) begin
      if (idx0 == IDX_LAST) begin
        addr0 <= BASE0;
        idx0  <= '0;
      end else begin
        addr0 <= addr0 + STEP;
        idx0  <= idx0 + 1'b1;
      end
    end
  end

  // Requester-1 address counter, same behaviour over its own region.
  always_ff @(posedge clk) begin
    if (rst || m1_done_i) begin
      addr1 <= BASE1;
      idx1  <= '0;
    end else if (xfer1) begin
      if (idx1 == IDX_LAST) begin
        addr1 <= BASE1;
        idx1  <= '0;
      end else begin
        addr1 <= addr1 + STEP;
        idx1  <= idx1 + 1'b1;
      end
    end
  end

  // Registered BRAM port: one write the cycle after each transfer; address and data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_o  <= '0;
      ram_dout_o  <= '0;
      ram_en_o    <= 1'b0;
      ram_wr_en_o <= 4'b0000;
    end else if (xfer0) begin
      ram_addr_o  <= addr0;
      ram_dout_o  <= 32'(m0_data_i);
      ram_en_o    <= 1'b1;
      ram_wr_en_o <= 4'b1111;
    end else if (xfer1) begin
      ram_addr_o  <= addr1;
      ram_dout_o  <= 32'(m1_data_i);
      ram_en_o    <= 1'b1;
      ram_wr_en_o <= 4'b1111;
    end else begin
      ram_en_o    <= 1'b0;
      ram_wr_en_o <= 4'b0000;
    end
  end

`ifdef RAM_PORT_ARB_STATS_EN
  // Per-requester transfer counters, cleared alongside that requester's address rewind.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_words_o <= '0;
      m1_words_o <= '0;
    end else begin
      if (m0_done_i) begin
        m0_words_o <= '0;
      end else if (xfer0) begin
        m0_words_o <= m0_words_o + 32'd1;
      end
      if (m1_done_i) begin
        m1_words_o <= '0;
      end else if (xfer1) begin
        m1_words_o <= m1_words_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed-vector bench for ram_port_arb.
// The DUT is built with BURST_LEN=4 and REGION_WORDS=8 so that burst limits and wrap are reachable.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_ram_port_arb;

  logic        clk;
  logic        rst;
  logic        m0_valid_i;
  logic [23:0] m0_data_i;
  logic        m0_done_i;
  logic        m0_ready_o;
  logic        m1_valid_i;
  logic [23:0] m1_data_i;
  logic        m1_done_i;
  logic        m1_ready_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_dout_o;
  logic        ram_en_o;
  logic [3:0]  ram_wr_en_o;
  logic [1:0]  grant_o;
`ifdef RAM_PORT_ARB_STATS_EN
  logic [31:0] m0_words_o;
  logic [31:0] m1_words_o;
`endif

  int total;
  int bad;

  ram_port_arb #(
    .DATA_WIDTH  (24),
    .ADDR_STEP   (4),
    .BASE0       (32'h0000_0000),
    .BASE1       (32'h0001_0000),
    .REGION_WORDS(8),
    .BURST_LEN   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_valid_i (m0_valid_i),
    .m0_data_i  (m0_data_i),
    .m0_done_i  (m0_done_i),
    .m0_ready_o (m0_ready_o),
    .m1_valid_i (m1_valid_i),
    .m1_data_i  (m1_data_i),
    .m1_done_i  (m1_done_i),
    .m1_ready_o (m1_ready_o),
    .ram_addr_o (ram_addr_o),
    .ram_dout_o (ram_dout_o),
    .ram_en_o   (ram_en_o),
    .ram_wr_en_o(ram_wr_en_o),
    .grant_o    (grant_o)
`ifdef RAM_PORT_ARB_STATS_EN
    ,
    .m0_words_o (m0_words_o),
    .m1_words_o (m1_words_o)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return on the following falling edge.
  task automatic applyStimulus(input logic rs,
                               input logic v0, input logic [23:0] d0, input logic dn0,
                               input logic v1, input logic [23:0] d1, input logic dn1);
    rst        = rs;
    m0_valid_i = v0;
    m0_data_i  = d0;
    m0_done_i  = dn0;
    m1_valid_i = v1;
    m1_data_i  = d1;
    m1_done_i  = dn1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkCycle(input string tag, input logic en, input logic [31:0] addr,
                            input logic [31:0] dout, input logic [1:0] grant);
    checkOutput({tag, ".en"}, {31'd0, ram_en_o}, {31'd0, en});
    checkOutput({tag, ".we"}, {28'd0, ram_wr_en_o}, en ? 32'hF : 32'h0);
    checkOutput({tag, ".addr"}, ram_addr_o, addr);
    checkOutput({tag, ".dout"}, ram_dout_o, dout);
    checkOutput({tag, ".grant"}, {30'd0, grant_o}, {30'd0, grant});
    checkOutput({tag, ".rdy0"}, {31'd0, m0_ready_o}, {31'd0, grant[0]});
    checkOutput({tag, ".rdy1"}, {31'd0, m1_ready_o}, {31'd0, grant[1]});
  endtask

  task automatic checkWords(input string tag, input logic [31:0] w0, input logic [31:0] w1);
`ifdef RAM_PORT_ARB_STATS_EN
    checkOutput({tag, ".w0"}, m0_words_o, w0);
    checkOutput({tag, ".w1"}, m1_words_o, w1);
`else
    if (w0 == w1 && tag == "") begin
      $display("[TB] no stats ports in this build");
    end
`endif
  endtask

  // Directed sequence; every expected value below is worked out by hand.
  initial begin
    total = 0;
    bad   = 0;

    // Reset state
    applyStimulus(1, 0, 24'h0, 0, 0, 24'h0, 0);
    applyStimulus(1, 0, 24'h0, 0, 0, 24'h0, 0);
    checkCycle("rst", 0, 32'h0, 32'h0, 2'b00);
    checkWords("rst", 32'd0, 32'd0);

    // Only m0 valid, five words, burst limit of 4 forces one idle gap
    applyStimulus(0, 1, 24'h0000A1, 0, 0, 24'h0, 0); checkCycle("m0a", 0, 32'h0,  32'h0,   2'b01);
    applyStimulus(0, 1, 24'h0000A1, 0, 0, 24'h0, 0); checkCycle("m0b", 1, 32'h0,  32'hA1,  2'b01);
    applyStimulus(0, 1, 24'h0000A2, 0, 0, 24'h0, 0); checkCycle("m0c", 1, 32'h4,  32'hA2,  2'b01);
    applyStimulus(0, 1, 24'h0000A3, 0, 0, 24'h0, 0); checkCycle("m0d", 1, 32'h8,  32'hA3,  2'b01);
    applyStimulus(0, 1, 24'h0000A4, 0, 0, 24'h0, 0); checkCycle("m0e", 1, 32'hC,  32'hA4,  2'b00);
    applyStimulus(0, 1, 24'h0000A5, 0, 0, 24'h0, 0); checkCycle("m0f", 0, 32'hC,  32'hA4,  2'b01);
    applyStimulus(0, 1, 24'h0000A5, 0, 0, 24'h0, 0); checkCycle("m0g", 1, 32'h10, 32'hA5,  2'b01);
    applyStimulus(0, 0, 24'h0,      0, 0, 24'h0, 0); checkCycle("m0h", 0, 32'h10, 32'hA5,  2'b00);

    // Reset in the middle of a grant with m0 at 0x14; the coinciding word is dropped
    applyStimulus(0, 1, 24'h0000B1, 0, 0, 24'h0, 0); checkCycle("rsta", 0, 32'h10, 32'hA5, 2'b01);
    applyStimulus(1, 1, 24'h0000B1, 0, 0, 24'h0, 0); checkCycle("rstb", 0, 32'h0,  32'h0,  2'b00);

    // Both valid: m0 wins the first tie, then 4-beat bursts alternate with one idle cycle
    applyStimulus(0, 1, 24'h0000C1, 0, 1, 24'h0000D1, 0); checkCycle("tie01", 0, 32'h0,      32'h0,  2'b01);
    applyStimulus(0, 1, 24'h0000C1, 0, 1, 24'h0000D1, 0); checkCycle("tie02", 1, 32'h0,      32'hC1, 2'b01);
    applyStimulus(0, 1, 24'h0000C2, 0, 1, 24'h0000D1, 0); checkCycle("tie03", 1, 32'h4,      32'hC2, 2'b01);
    applyStimulus(0, 1, 24'h0000C3, 0, 1, 24'h0000D1, 0); checkCycle("tie04", 1, 32'h8,      32'hC3, 2'b01);
    applyStimulus(0, 1, 24'h0000C4, 0, 1, 24'h0000D1, 0); checkCycle("tie05", 1, 32'hC,      32'hC4, 2'b00);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D1, 0); checkCycle("tie06", 0, 32'hC,      32'hC4, 2'b10);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D1, 0); checkCycle("tie07", 1, 32'h1_0000, 32'hD1, 2'b10);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D2, 0); checkCycle("tie08", 1, 32'h1_0004, 32'hD2, 2'b10);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D3, 0); checkCycle("tie09", 1, 32'h1_0008, 32'hD3, 2'b10);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D4, 0); checkCycle("tie10", 1, 32'h1_000C, 32'hD4, 2'b00);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D5, 0); checkCycle("tie11", 0, 32'h1_000C, 32'hD4, 2'b01);
    applyStimulus(0, 1, 24'h0000C5, 0, 1, 24'h0000D5, 0); checkCycle("tie12", 1, 32'h10,     32'hC5, 2'b01);
    applyStimulus(0, 0, 24'h0,      0, 0, 24'h0,      0); checkCycle("tie13", 0, 32'h10,     32'hC5, 2'b00);
    checkWords("tie", 32'd5, 32'd4);

    // Rewind m0, then nine words: the ninth wraps back to the region base
    applyStimulus(0, 0, 24'h0,      1, 0, 24'h0, 0); checkCycle("wrp00", 0, 32'h10, 32'hC5, 2'b00);
    checkWords("wrp", 32'd0, 32'd4);
    applyStimulus(0, 1, 24'h0000E1, 0, 0, 24'h0, 0); checkCycle("wrp01", 0, 32'h10, 32'hC5, 2'b01);
    applyStimulus(0, 1, 24'h0000E1, 0, 0, 24'h0, 0); checkCycle("wrp02", 1, 32'h0,  32'hE1, 2'b01);
    applyStimulus(0, 1, 24'h0000E2, 0, 0, 24'h0, 0); checkCycle("wrp03", 1, 32'h4,  32'hE2, 2'b01);
    applyStimulus(0, 1, 24'h0000E3, 0, 0, 24'h0, 0); checkCycle("wrp04", 1, 32'h8,  32'hE3, 2'b01);
    applyStimulus(0, 1, 24'h0000E4, 0, 0, 24'h0, 0); checkCycle("wrp05", 1, 32'hC,  32'hE4, 2'b00);
    applyStimulus(0, 1, 24'h0000E5, 0, 0, 24'h0, 0); checkCycle("wrp06", 0, 32'hC,  32'hE4, 2'b01);
    applyStimulus(0, 1, 24'h0000E5, 0, 0, 24'h0, 0); checkCycle("wrp07", 1, 32'h10, 32'hE5, 2'b01);
    applyStimulus(0, 1, 24'h0000E6, 0, 0, 24'h0, 0); checkCycle("wrp08", 1, 32'h14, 32'hE6, 2'b01);
    applyStimulus(0, 1, 24'h0000E7, 0, 0, 24'h0, 0); checkCycle("wrp09", 1, 32'h18, 32'hE7, 2'b01);
    applyStimulus(0, 1, 24'h0000E8, 0, 0, 24'h0, 0); checkCycle("wrp10", 1, 32'h1C, 32'hE8, 2'b00);
    applyStimulus(0, 1, 24'h0000E9, 0, 0, 24'h0, 0); checkCycle("wrp11", 0, 32'h1C, 32'hE8, 2'b01);
    applyStimulus(0, 1, 24'h0000E9, 0, 0, 24'h0, 0); checkCycle("wrp12", 1, 32'h0,  32'hE9, 2'b01);
    applyStimulus(0, 0, 24'h0,      0, 0, 24'h0, 0); checkCycle("wrp13", 0, 32'h0,  32'hE9, 2'b00);

    // m1 done on the transfer at 0x1_0008: that word lands there, the next goes to the base
    applyStimulus(0, 0, 24'h0, 0, 0, 24'h0,      1); checkCycle("dn1a", 0, 32'h0,      32'hE9,       2'b00);
    applyStimulus(0, 0, 24'h0, 0, 1, 24'hFFFF01, 0); checkCycle("dn1b", 0, 32'h0,      32'hE9,       2'b10);
    applyStimulus(0, 0, 24'h0, 0, 1, 24'hFFFF01, 0); checkCycle("dn1c", 1, 32'h1_0000, 32'h00FFFF01, 2'b10);
    applyStimulus(0, 0, 24'h0, 0, 1, 24'hFFFF02, 0); checkCycle("dn1d", 1, 32'h1_0004, 32'h00FFFF02, 2'b10);
    applyStimulus(0, 0, 24'h0, 0, 1, 24'hFFFF03, 1); checkCycle("dn1e", 1, 32'h1_0008, 32'h00FFFF03, 2'b10);
    applyStimulus(0, 0, 24'h0, 0, 1, 24'hFFFF04, 0); checkCycle("dn1f", 1, 32'h1_0000, 32'h00FFFF04, 2'b00);
    applyStimulus(0, 0, 24'h0, 0, 0, 24'h0,      0); checkCycle("dn1g", 0, 32'h1_0000, 32'h00FFFF04, 2'b00);

    // Transfer counters: rewind both, then 3 m0 words and 2 m1 words, then clear m0
    applyStimulus(0, 0, 24'h0,      1, 0, 24'h0,      1); checkCycle("st01", 0, 32'h1_0000, 32'h00FFFF04, 2'b00);
    checkWords("st01", 32'd0, 32'd0);
    applyStimulus(0, 1, 24'h123401, 0, 0, 24'h0,      0); checkCycle("st02", 0, 32'h1_0000, 32'h00FFFF04, 2'b01);
    applyStimulus(0, 1, 24'h123401, 0, 0, 24'h0,      0); checkCycle("st03", 1, 32'h0,      32'h00123401, 2'b01);
    applyStimulus(0, 1, 24'h123402, 0, 0, 24'h0,      0); checkCycle("st04", 1, 32'h4,      32'h00123402, 2'b01);
    applyStimulus(0, 1, 24'h123403, 0, 0, 24'h0,      0); checkCycle("st05", 1, 32'h8,      32'h00123403, 2'b01);
    applyStimulus(0, 0, 24'h0,      0, 1, 24'h800001, 0); checkCycle("st06", 0, 32'h8,      32'h00123403, 2'b00);
    applyStimulus(0, 0, 24'h0,      0, 1, 24'h800001, 0); checkCycle("st07", 0, 32'h8,      32'h00123403, 2'b10);
    applyStimulus(0, 0, 24'h0,      0, 1, 24'h800001, 0); checkCycle("st08", 1, 32'h1_0000, 32'h00800001, 2'b10);
    applyStimulus(0, 0, 24'h0,      0, 1, 24'h800002, 0); checkCycle("st09", 1, 32'h1_0004, 32'h00800002, 2'b10);
    applyStimulus(0, 0, 24'h0,      0, 0, 24'h0,      0); checkCycle("st10", 0, 32'h1_0004, 32'h00800002, 2'b00);
    checkWords("st10", 32'd3, 32'd2);
    applyStimulus(0, 0, 24'h0,      1, 0, 24'h0,      0); checkCycle("st11", 0, 32'h1_0004, 32'h00800002, 2'b00);
    checkWords("st11", 32'd0, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
